// File: rtl/ext_pipe_if.sv
// Stream bundle for ext_pipe: immediate/op beats in, extended words out.
// The slave side is the extender, the master side is the surrounding datapath.
interface ext_pipe_if #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  in_imm;
    logic [2:0]        in_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    modport slave (
        input  in_valid, in_imm, in_op, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_imm, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/ext_pipe.sv
// Pipelined immediate extender with a two-entry skid buffer on a valid/ready stream.
// The state register bits are out_valid (bit 1) and s_valid (bit 0).
module ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int SHAMT  = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    ext_pipe_if.slave    bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [DATA_W-1:0] out_data_r;
    logic              out_err_r;
    logic [DATA_W-1:0] s_data_r;
    logic              s_err_r;
    logic [DATA_W-1:0] ext_data_s;
    logic              ext_err_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              oreg_load_s;
    logic              oreg_from_skid_s;
    logic              sreg_load_s;

    // Returns {err, data}; every mode is formed at DATA_W so shifts never drop imm bits.
    function automatic logic [DATA_W:0] extend(input logic [IMM_W-1:0] imm, input logic [2:0] op);
        logic [DATA_W-1:0] sx;
        logic [DATA_W-1:0] zx;
        logic [DATA_W:0]   res;
        sx = DATA_W'($signed(imm));
        zx = DATA_W'(imm);
        case (op)
            3'b000:  res = {1'b0, sx};
            3'b001:  res = {1'b0, zx};
            3'b010:  res = {1'b0, zx << (DATA_W - IMM_W)};
            3'b011:  res = {1'b0, sx << SHAMT};
            3'b100:  res = {1'b0, zx << SHAMT};
            default: res = {1'b1, {DATA_W{1'b0}}};
        endcase
        return res;
    endfunction

    assign bus.out_valid = state_r[1];
    assign bus.in_ready  = ~state_r[0];
    assign bus.out_data  = out_data_r;
    assign bus.out_err   = out_err_r;

    // Input-side extension of the offered beat.
    always_comb begin
        {ext_err_s, ext_data_s} = extend(bus.in_imm, bus.in_op);
    end

    // Next-state and register load selection from the two handshakes.
    always_comb begin
        state_s          = state_r;
        oreg_load_s      = 1'b0;
        oreg_from_skid_s = 1'b0;
        sreg_load_s      = 1'b0;
        in_fire_s        = bus.in_valid & ~state_r[0];
        out_fire_s       = state_r[1] & bus.out_ready;
        case (state_r)
            EMPTY: begin
                if (in_fire_s) begin
                    oreg_load_s = 1'b1;
                    state_s     = ONE;
                end else begin
                    state_s = EMPTY;
                end
            end
            ONE: begin
                if (in_fire_s && out_fire_s) begin
                    oreg_load_s = 1'b1;
                    state_s     = ONE;
                end else if (out_fire_s) begin
                    state_s = EMPTY;
                end else if (in_fire_s) begin
                    sreg_load_s = 1'b1;
                    state_s     = FULL;
                end else begin
                    state_s = ONE;
                end
            end
            FULL: begin
                if (out_fire_s) begin
                    oreg_load_s      = 1'b1;
                    oreg_from_skid_s = 1'b1;
                    state_s          = ONE;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = EMPTY;
            end
        endcase
    end

    // Occupancy register; doubles as out_valid / s_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Output register: loads from the skid entry first so order stays FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_r <= {DATA_W{1'b0}};
            out_err_r  <= 1'b0;
        end else if (oreg_load_s) begin
            if (oreg_from_skid_s) begin
                out_data_r <= s_data_r;
                out_err_r  <= s_err_r;
            end else begin
                out_data_r <= ext_data_s;
                out_err_r  <= ext_err_s;
            end
        end else begin
            out_data_r <= out_data_r;
            out_err_r  <= out_err_r;
        end
    end

    // Skid register: captures a beat accepted while the output is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_data_r <= {DATA_W{1'b0}};
            s_err_r  <= 1'b0;
        end else if (sreg_load_s) begin
            s_data_r <= ext_data_s;
            s_err_r  <= ext_err_s;
        end else begin
            s_data_r <= s_data_r;
            s_err_r  <= s_err_r;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed and random beats against a queue-based
// reference, plus a small check of a narrower parameter set.
module tb_ext_pipe;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    int   n_in   = 0;
    int   n_out  = 0;
    logic        stall_q  = 1'b0;
    logic [31:0] hold_q   = 32'h0;
    logic [32:0] q[$];

    ext_pipe_if #(.IMM_W(16), .DATA_W(32)) b();
    ext_pipe_if #(.IMM_W(12), .DATA_W(24)) b2();

    ext_pipe #(.IMM_W(16), .DATA_W(32), .SHAMT(2)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b)
    );

    ext_pipe #(.IMM_W(12), .DATA_W(24), .SHAMT(1)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, result reduced modulo 2**dw.
    function automatic logic [32:0] ext_model(input int unsigned imm, input int op,
                                              input int iw, input int dw, input int sh);
        longint v;
        longint m;
        longint s;
        m = longint'(1) << dw;
        s = (imm >= (longint'(1) << (iw - 1))) ? longint'(imm) - (longint'(1) << iw) : longint'(imm);
        case (op)
            0: v = s;
            1: v = longint'(imm);
            2: v = longint'(imm) * (longint'(1) << (dw - iw));
            3: v = s * (longint'(1) << sh);
            4: v = longint'(imm) * (longint'(1) << sh);
            default: return {1'b1, 32'h0};
        endcase
        v = v % m;
        if (v < 0) v = v + m;
        return {1'b0, v[31:0]};
    endfunction

    // One cycle on the main DUT: drive, check state against the queue, account the handshakes.
    task automatic step(input logic v, input logic [15:0] imm, input logic [2:0] op,
                        input logic rdy, input logic [31:0] ed, input logic ee);
        logic        ifire;
        logic        ofire;
        logic [32:0] e;
        @(negedge clk);
        b.in_valid  = v;
        b.in_imm    = imm;
        b.in_op     = op;
        b.out_ready = rdy;
        #1;
        chk("in_ready", 33'(b.in_ready), 33'(q.size() < 2));
        chk("out_valid", 33'(b.out_valid), 33'(q.size() > 0));
        if (stall_q) chk("hold", 33'(b.out_data), 33'(hold_q));
        ifire = v && b.in_ready;
        ofire = b.out_valid && rdy;
        if (ofire) begin
            n_out++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_beat", {b.out_err, b.out_data}, e);
            end else begin
                chk("out_underflow", 33'(1), 33'(0));
            end
        end
        if (ifire) begin
            q.push_back({ee, ed});
            n_in++;
        end
        stall_q = b.out_valid && !rdy;
        hold_q  = b.out_data;
        @(posedge clk);
    endtask

    task automatic rstep(input logic v, input logic rdy);
        logic [15:0] imm;
        logic [2:0]  op;
        logic [32:0] e;
        imm = 16'($urandom);
        op  = 3'($urandom_range(0, 7));
        e   = ext_model(imm, op, 16, 32, 2);
        step(v, imm, op, rdy, e[31:0], e[32]);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            if (q.size() > 0) step(1'b0, 16'h0, 3'b000, 1'b1, 32'h0, 1'b0);
        end
        step(1'b0, 16'h0, 3'b000, 1'b1, 32'h0, 1'b0);
        chk("drain_count", 33'(n_out), 33'(n_in));
    endtask

    initial begin
        reset_n      = 1'b0;
        b.in_valid   = 1'b0;
        b.in_imm     = 16'h0;
        b.in_op      = 3'b000;
        b.out_ready  = 1'b0;
        b2.in_valid  = 1'b0;
        b2.in_imm    = 12'h0;
        b2.in_op     = 3'b000;
        b2.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 33'(b.out_valid), 33'(0));
        chk("rst_in_ready", 33'(b.in_ready), 33'(1));
        chk("rst_out", {b.out_err, b.out_data}, 33'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Each legal mode back to back.
        step(1'b1, 16'h8000, 3'b000, 1'b1, 32'hFFFF8000, 1'b0);
        step(1'b1, 16'h8000, 3'b001, 1'b1, 32'h00008000, 1'b0);
        step(1'b1, 16'h1234, 3'b010, 1'b1, 32'h12340000, 1'b0);
        step(1'b1, 16'hFFFF, 3'b011, 1'b1, 32'hFFFFFFFC, 1'b0);
        step(1'b1, 16'h0003, 3'b100, 1'b1, 32'h0000000C, 1'b0);
        // Illegal op flows through with err, next legal beat clears it.
        step(1'b1, 16'h7FFF, 3'b110, 1'b1, 32'h00000000, 1'b1);
        step(1'b1, 16'h0001, 3'b001, 1'b1, 32'h00000001, 1'b0);
        drain();

        // Backpressure: A and B fill the buffer, C waits, then everything drains in order.
        step(1'b1, 16'h0001, 3'b001, 1'b0, 32'h1, 1'b0);
        step(1'b1, 16'h0002, 3'b001, 1'b0, 32'h2, 1'b0);
        step(1'b1, 16'h0003, 3'b001, 1'b0, 32'h3, 1'b0);
        step(1'b1, 16'h0003, 3'b001, 1'b0, 32'h3, 1'b0);
        step(1'b1, 16'h0003, 3'b001, 1'b1, 32'h3, 1'b0);
        step(1'b1, 16'h0003, 3'b001, 1'b1, 32'h3, 1'b0);
        drain();

        // Alternating consumer with a continuous producer.
        for (int i = 0; i < 40; i++) rstep(1'b1, (i % 2) == 0);
        drain();

        // Fully random traffic.
        for (int i = 0; i < 200; i++) rstep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();

        // Narrow parameter set on the second instance.
        @(negedge clk);
        b2.in_valid = 1'b1;
        b2.in_imm   = 12'h800;
        b2.in_op    = 3'b011;
        @(posedge clk);
        #1;
        chk("p2_sshift", {b2.out_valid, b2.out_err, 7'h0, b2.out_data}, {1'b1, 1'b0, 7'h0, 24'hFFF000});
        @(negedge clk);
        b2.in_imm = 12'hABC;
        b2.in_op  = 3'b010;
        @(posedge clk);
        #1;
        chk("p2_upper", {b2.out_valid, b2.out_err, 7'h0, b2.out_data}, {1'b1, 1'b0, 7'h0, 24'hABC000});
        @(negedge clk);
        b2.in_valid = 1'b0;

        // Fill to FULL, then reset asynchronously mid-cycle.
        step(1'b1, 16'h1111, 3'b001, 1'b0, 32'h1111, 1'b0);
        step(1'b1, 16'h2222, 3'b001, 1'b0, 32'h2222, 1'b0);
        #3;
        chk("pre_rst_in_ready", 33'(b.in_ready), 33'(0));
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 33'(b.out_valid), 33'(0));
        chk("async_in_ready", 33'(b.in_ready), 33'(1));
        chk("async_out", {b.out_err, b.out_data}, 33'h0);
        q.delete();
        stall_q = 1'b0;
        n_in    = 0;
        n_out   = 0;
        @(negedge clk);
        b.in_valid  = 1'b1;
        b.in_imm    = 16'h5555;
        b.in_op     = 3'b001;
        b.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ignores_input", 33'(b.out_valid), 33'(0));
        @(negedge clk);
        b.in_valid = 1'b0;
        reset_n    = 1'b1;
        step(1'b1, 16'h00F0, 3'b000, 1'b1, 32'h000000F0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
